// File: rtl/hermes_task_ejector.sv
// Receive-side Hermes edge-port ejector: buffers flits from the mesh, parses header/size,
// streams matching payloads to a credit-based sink. Optional counters: HERMES_EJECTOR_COUNTERS_EN.
module hermes_task_ejector #(
    parameter logic [15:0] EJECTOR_ADDRESS  = 16'h0000,
    parameter int          FLIT_SIZE        = 32,
    parameter int          BUFFER_DEPTH     = 8,
    parameter int          MAX_PAYLOAD_SIZE = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 noc_rx_i,
    output logic                 noc_credit_o,
    input  logic [FLIT_SIZE-1:0] noc_data_i,
    output logic                 sink_tx_o,
    input  logic                 sink_credit_i,
    output logic [FLIT_SIZE-1:0] sink_data_o,
    output logic                 sink_eop_o,
    output logic                 error_o,
    output logic [15:0]          pkt_count_o,
    output logic [15:0]          drop_count_o
);

    localparam int PTR_W = $clog2(BUFFER_DEPTH);

    typedef enum logic [1:0] {
        HEADER  = 2'd0,
        SIZE    = 2'd1,
        PAYLOAD = 2'd2,
        DROP    = 2'd3
    } state_t;

    logic [FLIT_SIZE-1:0] fifo_mem [BUFFER_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]       count_q;
    logic                 fifo_full, fifo_empty, wr_en, pop;
    logic [FLIT_SIZE-1:0] head;

    state_t               state_q, state_d;
    logic                 match_q, match_d;
    logic [15:0]          remaining_q, remaining_d;
    logic                 sink_tx_q, sink_tx_d;
    logic [FLIT_SIZE-1:0] sink_data_q, sink_data_d;
    logic                 sink_eop_q, sink_eop_d;
    logic                 error_q, error_d;
    logic                 size_zero, drop_pkt;

    assign fifo_full    = (count_q == (PTR_W+1)'(BUFFER_DEPTH));
    assign fifo_empty   = (count_q == '0);
    assign wr_en        = noc_rx_i && !fifo_full;
    assign noc_credit_o = !fifo_full;
    assign head         = fifo_mem[rd_ptr_q];

    // Size is judged on the whole flit so any upper bit set counts as oversize.
    assign size_zero = (head == '0);
    assign drop_pkt  = !match_q || (head > FLIT_SIZE'(MAX_PAYLOAD_SIZE));

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            fifo_mem[wr_ptr_q] <= noc_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({wr_en, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= HEADER;
            match_q     <= 1'b0;
            remaining_q <= '0;
            sink_tx_q   <= 1'b0;
            sink_data_q <= '0;
            sink_eop_q  <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            match_q     <= match_d;
            remaining_q <= remaining_d;
            sink_tx_q   <= sink_tx_d;
            sink_data_q <= sink_data_d;
            sink_eop_q  <= sink_eop_d;
            error_q     <= error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        match_d     = match_q;
        remaining_d = remaining_q;
        pop         = 1'b0;
        sink_tx_d   = 1'b0;
        sink_data_d = sink_data_q;
        sink_eop_d  = 1'b0;
        error_d     = 1'b0;
        case (state_q)
            HEADER: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    match_d = (head[15:0] == EJECTOR_ADDRESS);
                    state_d = SIZE;
                end
            end
            SIZE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    remaining_d = head[15:0];
                    if (drop_pkt) begin
                        error_d = 1'b1;
                        state_d = size_zero ? HEADER : DROP;
                    end else if (size_zero) begin
                        state_d = HEADER;
                    end else begin
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (!fifo_empty && sink_credit_i) begin
                    pop         = 1'b1;
                    sink_tx_d   = 1'b1;
                    sink_data_d = head;
                    sink_eop_d  = (remaining_q == 16'd1);
                    remaining_d = remaining_q - 16'd1;
                    if (remaining_q == 16'd1) state_d = HEADER;
                end
            end
            DROP: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    remaining_d = remaining_q - 16'd1;
                    // <= 1 also covers a huge size whose low 16 bits are zero.
                    if (remaining_q <= 16'd1) state_d = HEADER;
                end
            end
            default: state_d = HEADER;
        endcase
    end

    assign sink_tx_o   = sink_tx_q;
    assign sink_data_o = sink_data_q;
    assign sink_eop_o  = sink_eop_q;
    assign error_o     = error_q;

`ifdef HERMES_EJECTOR_COUNTERS_EN
    logic [15:0] pkt_count_q, drop_count_q;
    logic        pkt_done;

    assign pkt_done = pop && (((state_q == SIZE) && !drop_pkt && size_zero) ||
                              ((state_q == PAYLOAD) && (remaining_q == 16'd1)));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pkt_count_q  <= '0;
            drop_count_q <= '0;
        end else begin
            if (pkt_done && (pkt_count_q != 16'hFFFF))  pkt_count_q  <= pkt_count_q + 16'd1;
            if (error_d && (drop_count_q != 16'hFFFF))  drop_count_q <= drop_count_q + 16'd1;
        end
    end

    assign pkt_count_o  = pkt_count_q;
    assign drop_count_o = drop_count_q;
`else
    assign pkt_count_o  = 16'h0;
    assign drop_count_o = 16'h0;
`endif

endmodule

// File: tb/tb_hermes_task_ejector.sv
// Directed bench for hermes_task_ejector; expected counter values follow HERMES_EJECTOR_COUNTERS_EN.
module tb_hermes_task_ejector;

`ifdef HERMES_EJECTOR_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        noc_rx = 1'b0;
    logic [31:0] noc_data = '0;
    logic        sink_credit = 1'b0;
    logic        noc_credit, sink_tx, sink_eop, error;
    logic [31:0] sink_data;
    logic [15:0] pkt_count, drop_count;

    hermes_task_ejector dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .noc_rx_i      (noc_rx),
        .noc_credit_o  (noc_credit),
        .noc_data_i    (noc_data),
        .sink_tx_o     (sink_tx),
        .sink_credit_i (sink_credit),
        .sink_data_o   (sink_data),
        .sink_eop_o    (sink_eop),
        .error_o       (error),
        .pkt_count_o   (pkt_count),
        .drop_count_o  (drop_count)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          err_pulses = 0;
    logic [31:0] got_data[$];
    logic        got_eop[$];
    int          got_cyc[$];

    always @(posedge clk) cyc = cyc + 1;

    always @(negedge clk) begin
        if (sink_tx) begin
            got_data.push_back(sink_data);
            got_eop.push_back(sink_eop);
            got_cyc.push_back(cyc);
            $display("[%0t] sink flit %h eop=%0b", $time, sink_data, sink_eop);
        end
        if (error) err_pulses = err_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cexp(input int n);
        return CNT_EN ? 32'(n) : 32'd0;
    endfunction

    task automatic step(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_mon();
        got_data.delete();
        got_eop.delete();
        got_cyc.delete();
        err_pulses = 0;
    endtask

    task automatic send(input logic [31:0] d);
        int guard = 0;
        while (!noc_credit && guard < 200) begin
            step(1);
            guard++;
        end
        if (guard >= 200) check("send_credit_timeout", 32'(noc_credit), 32'd1);
        noc_rx   = 1'b1;
        noc_data = d;
        step(1);
        noc_rx   = 1'b0;
    endtask

    task automatic send_pkt(input logic [31:0] hdr, input logic [31:0] size,
                            input logic [31:0] base, input int n);
        $display("[%0t] send pkt hdr=%h size=%0d payloads=%0d", $time, hdr, size, n);
        send(hdr);
        send(size);
        for (int i = 0; i < n; i++) send(base + 32'(i));
    endtask

    int accepted;

    initial begin
        // Reset state
        step(2);
        check("rst_tx", 32'(sink_tx), 32'd0);
        check("rst_eop", 32'(sink_eop), 32'd0);
        check("rst_data", sink_data, 32'd0);
        check("rst_err", 32'(error), 32'd0);
        check("rst_pkt", 32'(pkt_count), 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        rst_n = 1'b1;
        step(1);
        check("rst_credit", 32'(noc_credit), 32'd1);

        // Single packet, sink always ready
        sink_credit = 1'b1;
        clear_mon();
        send_pkt(32'h0000_0000, 32'd3, 32'hA1, 3);
        step(6);
        check("t1_count", 32'(got_data.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("t1_data%0d", i), got_data[i], 32'hA1 + 32'(i));
            check($sformatf("t1_eop%0d", i), 32'(got_eop[i]), (i == 2) ? 32'd1 : 32'd0);
        end
        check("t1_consecutive", 32'(got_cyc[2] - got_cyc[0]), 32'd2);
        check("t1_pkt", 32'(pkt_count), cexp(1));
        check("t1_err", 32'(err_pulses), 32'd0);

        // Sink backpressure with credit pattern 1,0,0,1,1
        sink_credit = 1'b0;
        clear_mon();
        send_pkt(32'h0000_0000, 32'd3, 32'hA1, 3);
        step(2);
        check("t2_hold", 32'(got_data.size()), 32'd0);
        sink_credit = 1'b1; step(1);
        sink_credit = 1'b0; step(1);
        sink_credit = 1'b0; step(1);
        sink_credit = 1'b1; step(1);
        sink_credit = 1'b1; step(1);
        sink_credit = 1'b0;
        step(3);
        check("t2_count", 32'(got_data.size()), 32'd3);
        for (int i = 0; i < 3; i++)
            check($sformatf("t2_data%0d", i), got_data[i], 32'hA1 + 32'(i));
        check("t2_eop", 32'(got_eop[2]), 32'd1);
        check("t2_gap01", 32'(got_cyc[1] - got_cyc[0]), 32'd3);
        check("t2_gap12", 32'(got_cyc[2] - got_cyc[1]), 32'd1);

        // FIFO fill: 10 flits offered with sink stalled, only 8 fit
        clear_mon();
        send(32'h0000_0000);
        send(32'd10);
        step(3);
        accepted = 0;
        for (int i = 0; i < 10; i++) begin
            if (noc_credit) accepted++;
            noc_rx   = 1'b1;
            noc_data = 32'hB0 + 32'(i);
            step(1);
        end
        noc_rx = 1'b0;
        check("t2_accepted", 32'(accepted), 32'd8);
        check("t2_credit_full", 32'(noc_credit), 32'd0);
        check("t2_no_out", 32'(got_data.size()), 32'd0);
        sink_credit = 1'b1;
        step(12);
        check("t2_drain", 32'(got_data.size()), 32'd8);
        send(32'hB8);
        send(32'hB9);
        step(4);
        check("t2_total", 32'(got_data.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            check($sformatf("t2_fill_data%0d", i), got_data[i], 32'hB0 + 32'(i));
            check($sformatf("t2_fill_eop%0d", i), 32'(got_eop[i]), (i == 9) ? 32'd1 : 32'd0);
        end
        check("t2_pkt", 32'(pkt_count), cexp(3));

        // Wrong address then a good single-flit packet
        clear_mon();
        send_pkt(32'h0000_0102, 32'd4, 32'hC1, 4);
        send_pkt(32'h0000_0000, 32'd1, 32'hB1, 1);
        step(6);
        check("t3_count", 32'(got_data.size()), 32'd1);
        check("t3_data", got_data[0], 32'hB1);
        check("t3_eop", 32'(got_eop[0]), 32'd1);
        check("t3_err", 32'(err_pulses), 32'd1);
        check("t3_drop", 32'(drop_count), cexp(1));
        check("t3_pkt", 32'(pkt_count), cexp(4));

        // Oversize packet, then a zero-size packet
        clear_mon();
        send_pkt(32'h0000_0000, 32'd33, 32'hD00, 33);
        step(4);
        check("t4_over_count", 32'(got_data.size()), 32'd0);
        check("t4_over_err", 32'(err_pulses), 32'd1);
        check("t4_drop", 32'(drop_count), cexp(2));
        clear_mon();
        send_pkt(32'h0000_0000, 32'd0, 32'h0, 0);
        step(4);
        check("t4_zero_count", 32'(got_data.size()), 32'd0);
        check("t4_zero_err", 32'(err_pulses), 32'd0);
        check("t4_pkt", 32'(pkt_count), cexp(5));

        // Reset in the middle of a packet
        clear_mon();
        send_pkt(32'h0000_0000, 32'd5, 32'hE1, 2);
        step(1);
        rst_n = 1'b0;
        #1;
        check("t5_tx", 32'(sink_tx), 32'd0);
        check("t5_data", sink_data, 32'd0);
        check("t5_eop", 32'(sink_eop), 32'd0);
        check("t5_err", 32'(error), 32'd0);
        check("t5_pkt_clr", 32'(pkt_count), 32'd0);
        check("t5_drop_clr", 32'(drop_count), 32'd0);
        step(2);
        rst_n = 1'b1;
        step(1);
        check("t5_credit", 32'(noc_credit), 32'd1);
        check("t5_tx_after", 32'(sink_tx), 32'd0);
        clear_mon();
        send_pkt(32'h0000_0000, 32'd1, 32'hF1, 1);
        step(4);
        check("t5_count", 32'(got_data.size()), 32'd1);
        check("t5_new_data", got_data[0], 32'hF1);
        check("t5_new_eop", 32'(got_eop[0]), 32'd1);
        check("t5_pkt", 32'(pkt_count), cexp(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
